// File: rtl/pbvi_pkg.sv
// pbvi_pkg: shared types, arithmetic helpers, FSM state encoding and
// default problem sizes for the point-based value-iteration backup engine.
//   q16_t        unsigned Q0.16 value
//   q16_mul      truncating Q0.16 multiply, (x*y)[31:16]
//   q16_sat_add  Q0.16 add that clamps at 0xffff
//   cnt_w        counter width for an index range of n entries (min 1 bit)
package pbvi_pkg;

  typedef logic [15:0] q16_t;

  localparam int PBVI_NUM_POINTS  = 16;
  localparam int PBVI_NUM_ALPHA   = 16;
  localparam int PBVI_NUM_STATES  = 2;
  localparam int PBVI_NUM_ACTIONS = 3;
  localparam int PBVI_NUM_OBS     = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GAMMA,
    ST_DOT,
    ST_SEL,
    ST_ADD,
    ST_VAL,
    ST_ACT,
    ST_WR,
    ST_COMMIT
  } pbvi_state_e;

  function automatic q16_t q16_mul(input q16_t x, input q16_t y);
    logic [31:0] prod;
    prod = 32'(x) * 32'(y);
    return prod[31:16];
  endfunction

  function automatic q16_t q16_sat_add(input q16_t x, input q16_t y);
    logic [16:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    return sum[16] ? 16'hffff : sum[15:0];
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pbvi_backup_engine_mac.sv
// pbvi_mac: chained two-multiplier Q0.16 multiply-accumulate.
//   clk, rst        clock, asynchronous active-high reset
//   en              update the accumulator this cycle
//   clr             load the product instead of accumulating (first term)
//   chain           1: product = x*(y*z); 0: product = x*y
//   op_x/op_y/op_z  Q0.16 operands
//   acc             registered accumulator
//   acc_next        value the accumulator takes on an enabled edge; the
//                   engine taps it to finish a sum in the same cycle
module pbvi_mac
  import pbvi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        chain,
  input  logic [15:0] op_x,
  input  logic [15:0] op_y,
  input  logic [15:0] op_z,
  output logic [15:0] acc,
  output logic [15:0] acc_next
);

  q16_t inner;
  q16_t prod;

  always_comb begin
    inner    = chain ? q16_mul(op_y, op_z) : op_y;
    prod     = q16_mul(op_x, inner);
    acc_next = clr ? prod : q16_sat_add(acc, prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (en) acc <= acc_next;
  end

endmodule

// File: rtl/pbvi_backup_engine.sv
// pbvi_backup_engine: time-multiplexed PBVI backup. For each belief point
// it selects the best action and that action's backed-up alpha vector using
// a single MAC driven by a loop-nest FSM (p > a > o > i > s > s').
// Results collect in a shadow bank and are published atomically on done.
//   clk, rst                 clock, asynchronous active-high reset
//   start                    one-cycle request, sampled only in IDLE
//   discount, epsilon        Q0.16 discount factor / convergence threshold
//   belief, alpha_in         belief points, current alpha set
//   vec_reward, trans, observe  R(a,s), T(a,s,s'), Z(a,s',o)
//   busy, done               sweep running / one-cycle commit pulse
//   point_action, alpha_out  best action and alpha vector per point
//   delta, converged         max |alpha_out change| and delta <= epsilon
// Optional feature macro PBVI_DELTA_EN: when undefined, delta and converged
// are tied to 0 and no comparator is built.
module pbvi_backup_engine
  import pbvi_pkg::*;
#(
  parameter int NUM_POINTS  = PBVI_NUM_POINTS,
  parameter int NUM_ALPHA   = PBVI_NUM_ALPHA,
  parameter int NUM_STATES  = PBVI_NUM_STATES,
  parameter int NUM_ACTIONS = PBVI_NUM_ACTIONS,
  parameter int NUM_OBS     = PBVI_NUM_OBS,
  localparam int AW = cnt_w(NUM_ACTIONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   discount,
  input  logic [15:0]   belief     [NUM_POINTS][NUM_STATES],
  input  logic [15:0]   alpha_in   [NUM_ALPHA][NUM_STATES],
  input  logic [15:0]   vec_reward [NUM_ACTIONS][NUM_STATES],
  input  logic [15:0]   trans      [NUM_ACTIONS][NUM_STATES][NUM_STATES],
  input  logic [15:0]   observe    [NUM_ACTIONS][NUM_STATES][NUM_OBS],
  input  logic [15:0]   epsilon,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] point_action [NUM_POINTS],
  output logic [15:0]   alpha_out    [NUM_POINTS][NUM_STATES],
  output logic [15:0]   delta,
  output logic          converged
);

  localparam int PW = cnt_w(NUM_POINTS);
  localparam int IW = cnt_w(NUM_ALPHA);
  localparam int SW = cnt_w(NUM_STATES);
  localparam int OW = cnt_w(NUM_OBS);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_POINTS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_ALPHA - 1);
  localparam logic [SW-1:0] S_LAST = SW'(NUM_STATES - 1);
  localparam logic [AW-1:0] A_LAST = AW'(NUM_ACTIONS - 1);
  localparam logic [OW-1:0] O_LAST = OW'(NUM_OBS - 1);

  pbvi_state_e state_reg, state_next;

  logic [PW-1:0] p_idx;
  logic [AW-1:0] a_idx;
  logic [OW-1:0] o_idx;
  logic [IW-1:0] i_idx;
  logic [SW-1:0] s_idx, sp_idx;
  logic last_p, last_a, last_o, last_i, last_s, last_sp;

  q16_t g_cur      [NUM_STATES];  // candidate g for current i
  q16_t best_g     [NUM_STATES];  // best g over i for current o
  q16_t alpha_a    [NUM_STATES];  // running alpha for current action
  q16_t best_alpha [NUM_STATES];  // best alpha over actions for current point
  q16_t best_v, best_val;
  logic [AW-1:0] best_act;
  q16_t shadow [NUM_POINTS][NUM_STATES];
  logic [AW-1:0] shadow_act [NUM_POINTS];

  logic mac_en, mac_clr, mac_chain;
  q16_t op_x, op_y, op_z, mac_acc, mac_next;

  assign last_p  = (p_idx == P_LAST);
  assign last_a  = (a_idx == A_LAST);
  assign last_o  = (o_idx == O_LAST);
  assign last_i  = (i_idx == I_LAST);
  assign last_s  = (s_idx == S_LAST);
  assign last_sp = (sp_idx == S_LAST);

  pbvi_mac u_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (mac_en),
    .clr      (mac_clr),
    .chain    (mac_chain),
    .op_x     (op_x),
    .op_y     (op_y),
    .op_z     (op_z),
    .acc      (mac_acc),
    .acc_next (mac_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state plus MAC operand steering.
  always_comb begin
    state_next = state_reg;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    mac_chain  = 1'b0;
    op_x       = '0;
    op_y       = '0;
    op_z       = '0;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_GAMMA;
      ST_GAMMA: begin
        mac_en     = 1'b1;
        mac_clr    = (sp_idx == '0);
        mac_chain  = 1'b1;
        op_x       = trans[a_idx][s_idx][sp_idx];
        op_y       = observe[a_idx][sp_idx][o_idx];
        op_z       = alpha_in[i_idx][sp_idx];
        if (last_s && last_sp) state_next = ST_DOT;
      end
      ST_DOT: begin
        mac_en  = 1'b1;
        mac_clr = (s_idx == '0);
        op_x    = belief[p_idx][s_idx];
        op_y    = g_cur[s_idx];
        if (last_s) state_next = ST_SEL;
      end
      ST_SEL:    state_next = last_i ? ST_ADD : ST_GAMMA;
      ST_ADD:    state_next = last_o ? ST_VAL : ST_GAMMA;
      ST_VAL: begin
        mac_en  = 1'b1;
        mac_clr = (s_idx == '0);
        op_x    = belief[p_idx][s_idx];
        op_y    = alpha_a[s_idx];
        if (last_s) state_next = ST_ACT;
      end
      ST_ACT:    state_next = last_a ? ST_WR : ST_GAMMA;
      ST_WR:     state_next = last_p ? ST_COMMIT : ST_GAMMA;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_idx <= '0; a_idx <= '0; o_idx <= '0; i_idx <= '0; s_idx <= '0; sp_idx <= '0;
      best_v <= '0; best_val <= '0; best_act <= '0;
      busy <= 1'b0; done <= 1'b0;
      for (int s = 0; s < NUM_STATES; s++) begin
        g_cur[s] <= '0; best_g[s] <= '0; alpha_a[s] <= '0; best_alpha[s] <= '0;
      end
      for (int p = 0; p < NUM_POINTS; p++) begin
        shadow_act[p]   <= '0;
        point_action[p] <= '0;
        for (int s = 0; s < NUM_STATES; s++) begin
          shadow[p][s]    <= '0;
          alpha_out[p][s] <= '0;
        end
      end
    end else begin
      // busy trails the FSM by one cycle so it rises the cycle after start
      // is taken and falls together with the done pulse.
      busy <= (state_reg != ST_IDLE) && (state_reg != ST_COMMIT);
      done <= (state_reg == ST_COMMIT);
      case (state_reg)
        ST_IDLE: begin
          p_idx <= '0; a_idx <= '0; o_idx <= '0; i_idx <= '0; s_idx <= '0; sp_idx <= '0;
        end
        ST_GAMMA: begin
          // First MAC cycle of a new action seeds the running alpha with R(a,.).
          if (o_idx == '0 && i_idx == '0 && s_idx == '0 && sp_idx == '0)
            for (int s = 0; s < NUM_STATES; s++) alpha_a[s] <= vec_reward[a_idx][s];
          if (last_sp) begin
            g_cur[s_idx] <= q16_mul(discount, mac_next);
            sp_idx       <= '0;
            s_idx        <= last_s ? '0 : s_idx + 1'b1;
          end else begin
            sp_idx <= sp_idx + 1'b1;
          end
        end
        ST_DOT, ST_VAL: s_idx <= last_s ? '0 : s_idx + 1'b1;
        ST_SEL: begin
          // Strict compare: the lowest candidate index keeps a tie.
          if (i_idx == '0 || mac_acc > best_v) begin
            best_v <= mac_acc;
            for (int s = 0; s < NUM_STATES; s++) best_g[s] <= g_cur[s];
          end
          i_idx <= last_i ? '0 : i_idx + 1'b1;
        end
        ST_ADD: begin
          for (int s = 0; s < NUM_STATES; s++) alpha_a[s] <= q16_sat_add(alpha_a[s], best_g[s]);
          o_idx <= last_o ? '0 : o_idx + 1'b1;
        end
        ST_ACT: begin
          if (a_idx == '0 || mac_acc > best_val) begin
            best_val <= mac_acc;
            best_act <= a_idx;
            for (int s = 0; s < NUM_STATES; s++) best_alpha[s] <= alpha_a[s];
          end
          a_idx <= last_a ? '0 : a_idx + 1'b1;
        end
        ST_WR: begin
          shadow_act[p_idx] <= best_act;
          for (int s = 0; s < NUM_STATES; s++) shadow[p_idx][s] <= best_alpha[s];
          p_idx <= last_p ? '0 : p_idx + 1'b1;
        end
        ST_COMMIT: begin
          for (int p = 0; p < NUM_POINTS; p++) begin
            point_action[p] <= shadow_act[p];
            for (int s = 0; s < NUM_STATES; s++) alpha_out[p][s] <= shadow[p][s];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PBVI_DELTA_EN
  // During COMMIT alpha_out still holds the previous sweep, shadow the new one.
  q16_t diff [NUM_POINTS*NUM_STATES];
  q16_t delta_calc;
  q16_t delta_reg;
  logic converged_reg;

  generate
    for (genvar gi = 0; gi < NUM_POINTS*NUM_STATES; gi++) begin : g_diff
      localparam int PI = gi / NUM_STATES;
      localparam int SI = gi % NUM_STATES;
      assign diff[gi] = (shadow[PI][SI] >= alpha_out[PI][SI])
                      ? shadow[PI][SI] - alpha_out[PI][SI]
                      : alpha_out[PI][SI] - shadow[PI][SI];
    end
  endgenerate

  always_comb begin
    delta_calc = '0;
    for (int k = 0; k < NUM_POINTS*NUM_STATES; k++)
      if (diff[k] > delta_calc) delta_calc = diff[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delta_reg     <= '0;
      converged_reg <= 1'b0;
    end else if (state_reg == ST_COMMIT) begin
      delta_reg     <= delta_calc;
      converged_reg <= (delta_calc <= epsilon);
    end
  end

  assign delta     = delta_reg;
  assign converged = converged_reg;
`else
  logic unused_epsilon;
  assign unused_epsilon = ^epsilon;
  assign delta     = '0;
  assign converged = 1'b0;
`endif

endmodule
